// File: rtl/membus_wrr_arbiter.sv
// Two-master Membus arbiter with weighted round-robin grant and
// in-order response routing through a small source-id FIFO.
module membus_wrr_arbiter #(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 64,
   parameter int M0_WEIGHT       = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m0_valid,
   output logic                    m0_ready,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic                    m0_wen,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_wmask,
   output logic                    m0_rvalid,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   input  logic                    m1_valid,
   output logic                    m1_ready,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic                    m1_wen,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_wmask,
   output logic                    m1_rvalid,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ADDR_WIDTH-1:0]   out_addr,
   output logic                    out_wen,
   output logic [DATA_WIDTH-1:0]   out_wdata,
   output logic [DATA_WIDTH/8-1:0] out_wmask,
   input  logic                    out_rvalid,
   input  logic [DATA_WIDTH-1:0]   out_rdata
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [CW-1:0]              count_q, count_d;
   logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [MAX_OUTSTANDING-1:0] src_q, src_d;
   logic [3:0]                 streak_q, streak_d;
   logic                       last_grant_q, last_grant_d;

   logic grant;
   logic fifo_full;
   logic req_valid;
   logic push;
   logic pop;
   logic head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      ptr_inc = (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   // Grant selection, request mux and response routing
   always_comb begin
      grant = last_grant_q;
      if (m0_valid && m1_valid) begin
         grant = (streak_q == 4'(M0_WEIGHT));
      end else if (m0_valid) begin
         grant = 1'b0;
      end else if (m1_valid) begin
         grant = 1'b1;
      end
      fifo_full = (count_q == CW'(MAX_OUTSTANDING));
      req_valid = grant ? m1_valid : m0_valid;
      out_valid = req_valid && !fifo_full;
      out_addr  = grant ? m1_addr  : m0_addr;
      out_wen   = grant ? m1_wen   : m0_wen;
      out_wdata = grant ? m1_wdata : m0_wdata;
      out_wmask = grant ? m1_wmask : m0_wmask;
      m0_ready  = out_valid && out_ready && !grant;
      m1_ready  = out_valid && out_ready && grant;
      push      = out_valid && out_ready;
      pop       = out_rvalid && (count_q != '0);
      head      = src_q[rd_ptr_q];
      m0_rvalid = pop && !head;
      m1_rvalid = pop && head;
      m0_rdata  = out_rdata;
      m1_rdata  = out_rdata;
   end

   // Next-state for FIFO, streak counter and last grant
   always_comb begin
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      src_d        = src_q;
      streak_d     = streak_q;
      last_grant_d = last_grant_q;
      if (push) begin
         src_d[wr_ptr_q] = grant;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
         last_grant_d    = grant;
         if (!grant && m1_valid) begin
            if (streak_q != 4'(M0_WEIGHT)) begin
               streak_d = streak_q + 4'd1;
            end
         end else begin
            streak_d = '0;
         end
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         src_q        <= '0;
         streak_q     <= '0;
         last_grant_q <= 1'b1;
      end else begin
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         src_q        <= src_d;
         streak_q     <= streak_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Flag a RAM response that arrives with nothing outstanding
   always_ff @(posedge clk) begin
      if (rst && out_rvalid) begin
         assert (count_q != '0)
         else $warning("membus_wrr_arbiter: out_rvalid with empty source fifo");
      end
   end

endmodule

// File: tb/tb_membus_wrr_arbiter.sv
// Bench for membus_wrr_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_membus_wrr_arbiter;

   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int MW   = DW / 8;
   localparam int W    = 4;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          m0_valid, m0_ready, m0_wen, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic [MW-1:0] m0_wmask;
   logic          m1_valid, m1_ready, m1_wen, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [MW-1:0] m1_wmask;
   logic          out_valid, out_ready, out_wen, out_rvalid;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_wdata, out_rdata;
   logic [MW-1:0] out_wmask;

   logic        ram_auto;
   logic        man_rvalid;
   logic        ram_rv = 1'b0;
   logic [31:0] rd_cnt = 32'd0;

   assign out_rvalid = ram_auto ? ram_rv : man_rvalid;
   assign out_rdata  = {32'hDA7A_0000, rd_cnt};

   membus_wrr_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .M0_WEIGHT(W), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
      .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
      .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_wen(out_wen), .out_wdata(out_wdata), .out_wmask(out_wmask),
      .out_rvalid(out_rvalid), .out_rdata(out_rdata)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Reference model: outstanding issuers in order, and how many M0
   // grants in a row M1 has had to sit through.
   int   q[$];
   int   run = 0;
   int   dut_log[$];
   logic p_hs, p_pop, p_g, p_m1v, hs_seen;
   logic e_full, e_g, e_v, e_pop;
   int   e_head;

   always @(negedge clk) begin
      if (rst) begin
         e_full = (q.size() == MAXO);
         if (m0_valid && m1_valid) e_g = (run == W);
         else                      e_g = m1_valid && !m0_valid;
         e_v = !e_full && (e_g ? m1_valid : m0_valid);
         chk("out_valid", out_valid, e_v);
         chk("m0_ready", m0_ready, e_v && out_ready && !e_g);
         chk("m1_ready", m1_ready, e_v && out_ready && e_g);
         if (e_v) begin
            chk("out_addr", out_addr, e_g ? m1_addr : m0_addr);
            chk("out_wen", out_wen, e_g ? m1_wen : m0_wen);
            chk("out_wdata", out_wdata, e_g ? m1_wdata : m0_wdata);
            chk("out_wmask", out_wmask, e_g ? m1_wmask : m0_wmask);
         end
         e_head = (q.size() > 0) ? q[0] : 0;
         e_pop  = out_rvalid && (q.size() > 0);
         chk("m0_rvalid", m0_rvalid, e_pop && e_head == 0);
         chk("m1_rvalid", m1_rvalid, e_pop && e_head == 1);
         chk("m0_rdata", m0_rdata, out_rdata);
         chk("m1_rdata", m1_rdata, out_rdata);
         if (m0_ready) dut_log.push_back(0);
         if (m1_ready) dut_log.push_back(1);
         p_hs    = e_v && out_ready;
         p_g     = e_g;
         p_pop   = e_pop;
         p_m1v   = m1_valid;
         hs_seen = out_valid && out_ready;
      end else begin
         p_hs    = 1'b0;
         p_pop   = 1'b0;
         p_g     = 1'b0;
         p_m1v   = 1'b0;
         hs_seen = 1'b0;
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         run = 0;
      end else begin
         if (p_pop) void'(q.pop_front());
         if (p_hs) begin
            q.push_back(p_g ? 1 : 0);
            if (!p_g && p_m1v) run = (run < W) ? run + 1 : W;
            else               run = 0;
         end
      end
   end

   // One-cycle RAM: answers each accepted request on the next cycle
   always @(posedge clk) begin
      #1;
      ram_rv = hs_seen;
      rd_cnt = rd_cnt + 32'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   int n0;
   int gv;

   initial begin
      rst = 1'b0;
      m0_valid = 0; m0_addr = '0; m0_wen = 0; m0_wdata = '0; m0_wmask = '0;
      m1_valid = 0; m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0;
      out_ready = 0; ram_auto = 0; man_rvalid = 0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      step();
      step();
      rst = 1'b1; out_ready = 1; ram_auto = 1;

      // single M0 read, 1-cycle RAM
      m0_valid = 1; m0_addr = 64'h8000_0010; m0_wen = 0;
      #3;
      chk("t1_out_addr", out_addr, 64'h8000_0010);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_m0_ready", m0_ready, 1);
      step();
      m0_valid = 0;
      #3;
      chk("t1_m0_rvalid", m0_rvalid, 1);
      chk("t1_m1_rvalid", m1_rvalid, 0);
      chk("t1_m0_rdata", m0_rdata, out_rdata);
      step();

      // both masters continuously valid
      n0 = dut_log.size();
      m0_valid = 1; m0_addr = 64'h8000_0100; m0_wdata = 64'h0A0A; m0_wmask = 8'h0F;
      m1_valid = 1; m1_addr = 64'h8000_0200; m1_wen = 1;
      m1_wdata = 64'h1B1B; m1_wmask = 8'hF0;
      repeat (12) step();
      m0_valid = 0; m1_valid = 0;
      step();
      step();
      for (int i = 0; i < 10; i++) begin
         gv = (n0 + i < dut_log.size()) ? dut_log[n0 + i] : 9;
         chk($sformatf("t2_grant%0d", i), 64'(gv), 64'(pat[i]));
      end

      // fill the fifo with two M1 writes, RAM withholds responses
      ram_auto = 0; man_rvalid = 0;
      m1_valid = 1; m1_wen = 1; m1_wmask = 8'hFF; m1_addr = 64'h8000_0300;
      #3 chk("t3_acc0", m1_ready, 1);
      step();
      #3 chk("t3_acc1", m1_ready, 1);
      step();
      #3;
      chk("t3_full_ready", m1_ready, 0);
      chk("t3_full_valid", out_valid, 0);
      step();
      step();
      step();
      man_rvalid = 1;
      #3;
      chk("t3_rv0", m1_rvalid, 1);
      chk("t3_full_rv_ready", m1_ready, 0);
      step();
      man_rvalid = 0;
      #3 chk("t3_resume", m1_ready, 1);
      step();
      m1_valid = 0; man_rvalid = 1;
      #3 chk("t3_rv1", m1_rvalid, 1);
      step();
      #3 chk("t3_rv2", m1_rvalid, 1);
      step();
      man_rvalid = 0;

      // push and pop in the same cycle
      m1_valid = 1; m1_wen = 0;
      step();
      m1_valid = 0; m0_valid = 1; m0_addr = 64'h8000_0400; man_rvalid = 1;
      #3;
      chk("t4_m1_rvalid", m1_rvalid, 1);
      chk("t4_m0_ready", m0_ready, 1);
      step();
      m0_valid = 0;
      #3;
      chk("t4_m0_rvalid", m0_rvalid, 1);
      chk("t4_m1_rvalid_b", m1_rvalid, 0);
      step();
      man_rvalid = 0;

      // stray response with nothing outstanding
      man_rvalid = 1;
      #3;
      chk("t5_m0_rvalid", m0_rvalid, 0);
      chk("t5_m1_rvalid", m1_rvalid, 0);
      step();
      man_rvalid = 0;

      // async reset with two requests outstanding
      m0_valid = 1;
      step();
      step();
      #2;
      rst = 1'b0; m0_valid = 0; man_rvalid = 1;
      #1;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_m0_ready", m0_ready, 0);
      chk("t6_m1_ready", m1_ready, 0);
      chk("t6_m0_rvalid", m0_rvalid, 0);
      chk("t6_m1_rvalid", m1_rvalid, 0);
      step();
      rst = 1'b1; m0_valid = 1; m1_valid = 1;
      #3;
      chk("t6_tie_m0", m0_ready, 1);
      chk("t6_tie_m1", m1_ready, 0);
      chk("t6_no_rvalid", m0_rvalid, 0);
      step();
      m0_valid = 0; m1_valid = 0;
      step();
      man_rvalid = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
